// File: rtl/dmem_sp.sv
// dmem_sp: single-port byte-lane data memory with registered read and init fill sequencer
module dmem_sp #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          req,
   input  logic          we,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          init_done,
   output logic          stall
);
   localparam int DEPTH = 2**AW;

   if (DW % 8 != 0) begin : g_dw_check
      $error("dmem_sp: DW must be a multiple of 8");
   end

   typedef enum logic {INIT, RUN} state_t;
   state_t        state;
   logic [AW-1:0] icnt;
   logic [DW-1:0] rd_word;
   logic          fill, run_rd, run_wr;

   // clr wins over any request in the same cycle; nothing is accepted while filling
   assign fill      = rst && state == INIT;
   assign run_rd    = state == RUN && req && !we && !clr;
   assign run_wr    = state == RUN && req && we && !clr;
   assign init_done = state == RUN;
   assign stall     = ~init_done;

   // one narrow array per byte lane so each lane maps to its own write-enabled RAM column
   for (genvar g = 0; g < DW/8; g++) begin : g_lane
      logic [7:0] mem [DEPTH];
      // lane write: init fill of the whole word, or this lane of a run write
      always_ff @(posedge clk)
         if (fill) mem[icnt] <= INIT_VAL[8*g +: 8];
         else if (run_wr && be[g]) mem[addr] <= wdata[8*g +: 8];
      assign rd_word[8*g +: 8] = mem[addr];
   end

   // control: fill sequencing, registered read data and its valid pulse
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= INIT;
         icnt   <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= run_rd;
         if (run_rd) rdata <= rd_word;
         if (clr) begin
            state <= INIT;
            icnt  <= '0;
         end else if (state == INIT) begin
            icnt <= icnt + AW'(1);
            if (icnt == AW'(DEPTH-1)) state <= RUN;
         end
      end
endmodule

// File: tb/tb_dmem_sp.sv
// tb_dmem_sp: directed self-checking bench for dmem_sp with 256 x 16 geometry
module tb_dmem_sp;
   logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, req = 1'b0, we = 1'b0;
   logic [1:0]  be = 2'b11;
   logic [7:0]  addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        rvalid, init_done, stall;
   logic        rv_seen = 1'b0;
   int          tests = 0, fails = 0;

   dmem_sp #(.DW(16), .AW(8), .INIT_VAL(16'hA5A5)) dut (
      .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .be(be),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .init_done(init_done), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick;
         rv_seen = rv_seen | rvalid;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      tick;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      req = 1'b1; we = 1'b0; addr = a;
      tick;
      req = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst_init_done", init_done, 0);
      chk("rst_stall", stall, 1);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 16'h0000);
      tick;
      tick;
      // requests held active for the whole fill must be ignored
      req = 1'b1; we = 1'b1; addr = 8'd5; wdata = 16'h5555; be = 2'b11;
      rst = 1'b1;
      rv_seen = 1'b0;
      run(255);
      chk("init_255_done", init_done, 0);
      chk("init_255_stall", stall, 1);
      run(1);
      chk("init_256_done", init_done, 1);
      chk("init_256_stall", stall, 0);
      chk("init_no_rvalid", rv_seen, 0);
      req = 1'b0; we = 1'b0;
      rd(8'd0);
      chk("rd0_valid", rvalid, 1);
      chk("rd0_data", rdata, 16'hA5A5);
      rd(8'd128);
      chk("rd128_valid", rvalid, 1);
      chk("rd128_data", rdata, 16'hA5A5);
      rd(8'd255);
      chk("rd255_valid", rvalid, 1);
      chk("rd255_data", rdata, 16'hA5A5);
      rd(8'd5);
      chk("rd5_data", rdata, 16'hA5A5);
      tick;
      chk("idle_rvalid", rvalid, 0);
      chk("idle_hold", rdata, 16'hA5A5);
      // write then read next cycle, back-to-back reads
      wr(8'd4, 16'hBEEF, 2'b11);
      wr(8'd3, 16'h2369, 2'b11);
      chk("wr_no_rvalid", rvalid, 0);
      chk("wr_rdata_hold", rdata, 16'hA5A5);
      rd(8'd3);
      chk("rd3_valid", rvalid, 1);
      chk("rd3_data", rdata, 16'h2369);
      rd(8'd4);
      chk("rd4_valid", rvalid, 1);
      chk("rd4_data", rdata, 16'hBEEF);
      tick;
      chk("b2b_drop", rvalid, 0);
      // byte enables
      wr(8'd7, 16'hFFFF, 2'b11);
      wr(8'd7, 16'h1200, 2'b10);
      wr(8'd7, 16'h0034, 2'b00);
      rd(8'd7);
      chk("be_hi_data", rdata, 16'h12FF);
      wr(8'd7, 16'hAB56, 2'b01);
      rd(8'd7);
      chk("be_lo_data", rdata, 16'h1256);
      // clr with a concurrent read
      wr(8'd9, 16'h0060, 2'b11);
      req = 1'b1; we = 1'b0; addr = 8'd9;
      tick;
      chk("clr_prev_valid", rvalid, 1);
      chk("clr_prev_data", rdata, 16'h0060);
      clr = 1'b1;
      tick;
      clr = 1'b0; req = 1'b0;
      chk("clr_rvalid", rvalid, 0);
      chk("clr_init_done", init_done, 0);
      chk("clr_rdata_hold", rdata, 16'h0060);
      rv_seen = 1'b0;
      run(255);
      chk("clr_255_done", init_done, 0);
      run(1);
      chk("clr_256_done", init_done, 1);
      chk("clr_no_rvalid", rv_seen, 0);
      rd(8'd9);
      chk("clr_rd9_valid", rvalid, 1);
      chk("clr_rd9_data", rdata, 16'hA5A5);
      // async reset 100 edges into a fill
      clr = 1'b1;
      tick;
      clr = 1'b0;
      run(99);
      chk("mid_init_done", init_done, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_init_done", init_done, 0);
      chk("arst_rvalid", rvalid, 0);
      chk("arst_rdata", rdata, 16'h0000);
      chk("arst_stall", stall, 1);
      rst = 1'b1;
      run(255);
      chk("arst_255_done", init_done, 0);
      run(1);
      chk("arst_256_done", init_done, 1);
      rd(8'd3);
      chk("arst_rd3_valid", rvalid, 1);
      chk("arst_rd3_data", rdata, 16'hA5A5);
      // async reset while a read result is being presented
      #2 rst = 1'b0;
      #1;
      chk("arst_run_rvalid", rvalid, 0);
      chk("arst_run_rdata", rdata, 16'h0000);
      chk("arst_run_done", init_done, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dmem_sp.md
# dmem_sp

Parametrised single-port data memory for the pipeline's MEM stage. It replaces the fixed 256 x 16 array that had a combinational read and a bulk reset preset. This block adds:
- a synchronous one-cycle read, so it maps to block RAM;
- per-byte write enables;
- a multi-cycle init sequencer that fills every word with a constant after reset or on a soft clear.

The pipeline must stall on `stall` until init completes.

## Interface
- `DW`, 16: data width in bits. Must be a multiple of 8; other values are illegal.
- `AW`, 8: address width; depth `DEPTH = 2**AW` words.
- `INIT_VAL`, 16'h0000 (`DW` bits): value written to every word during init.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous soft re-init request; single-cycle pulse or level.
- `req`  in  1  access request, sampled each cycle.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `be`  in  `DW/8`  byte-lane write enables. Bit i covers `wdata[8i+7:8i]`.
- `addr`  in  `AW`  word address.
- `wdata`  in  `DW`  write data.
- `rdata`  out  `DW`  read data, registered.
- `rvalid`  out  1  one-cycle pulse: `rdata` holds the result of the read accepted in the previous cycle.
- `init_done`  out  1  high when the memory is initialised and accepting requests.
- `stall`  out  1  combinational, equal to `~init_done`.

## Operation
- **States.** Two-state FSM: `INIT`, `RUN`. An init counter `icnt` is `AW` bits wide.
- **Reset.** `rst` low forces the following immediately:
  - state = `INIT`, `icnt` = 0;
  - `rdata` = 0, `rvalid` = 0, `init_done` = 0, `stall` = 1.
  - Array contents are not cleared by reset itself.
- **INIT.**
  - Each edge writes `INIT_VAL` to `mem[icnt]` (all lanes), then increments `icnt`.
  - On the edge that writes `icnt == DEPTH-1`: go to `RUN`, `init_done` becomes 1, `icnt` wraps to 0.
  - `req` is ignored in `INIT`: no memory write, no `rvalid`.
  - `clr` asserted in `INIT` restarts the fill: `icnt` becomes 0 on that edge.
- **RUN, read.** `req=1`, `we=0` at edge N: `rdata` = `mem[addr]` and `rvalid` = 1 after edge N. `rvalid` drops after edge N+1 unless another read is accepted.
- **RUN, write.**
  - `req=1`, `we=1` at edge N: for each lane i with `be[i]=1`, `mem[addr]` lane i = `wdata` lane i. Lanes with `be[i]=0` are unchanged.
  - `be` = 0 makes the write a no-op.
  - Writes never assert `rvalid` and never change `rdata`.
- **`rdata` hold.** `rdata` holds its last read value until the next accepted read; it is not cleared by `clr`.
- **`clr` in RUN.**
  - `clr=1` at edge N: state = `INIT`, `icnt` = 0, `init_done` = 0 after edge N.
  - Any `req` in the same cycle is dropped, with `clr` taking priority.
  - A read accepted at edge N-1 still produces its `rvalid` pulse after edge N-1. No later `rvalid` is produced until `RUN` is re-entered.
- **Ordering.** Single port, one operation per cycle. A write at edge N followed by a read of the same address at edge N+1 returns the new data after edge N+1.
- **Addressing.** The full `AW`-bit address space is valid, with no out-of-range case.

## Timing
- Read latency: 1 cycle from request edge to `rvalid`/`rdata`. Throughput is one access per cycle, any mix of reads and writes.
- Write latency: memory is updated at the request edge; the data is visible to a read issued the next cycle.
- Init duration: exactly `DEPTH` rising edges after `rst` deasserts (or after the `clr` edge). `init_done` is high after the `DEPTH`-th edge.
- `stall` follows `init_done` combinationally. The pipeline must hold its request stable while `stall=1`; the block does not queue requests.
- Reset asserted mid-init or mid-access: all outputs take their reset values asynchronously. An in-flight read's `rvalid` is lost. The fill restarts from address 0 after release.

## Test plan
- **Reset and init.** Defaults, `INIT_VAL`=16'hA5A5. Release `rst`, hold `req`=0: `init_done` rises after exactly 256 edges; reads of addresses 0, 128 and 255 return 16'hA5A5 with `rvalid` one cycle after each request.
- **Write/read latency.**
  - Write 16'h2369 to 3 at edge N, then read 3 at N+1: `rdata`=16'h2369 and `rvalid`=1 after N+1.
  - Back-to-back reads of 3 then 4 give two consecutive `rvalid` pulses.
- **Byte enables.** Write 16'hFFFF to 7 with `be`=2'b11. Then write 16'h1200 with `be`=2'b10, and 16'h0034 with `be`=2'b00. Read 7: 16'h12FF.
- **Requests during init.** Assert `req`=1, `we`=1, `addr`=5, `wdata`=16'h5555 throughout init: no effect; after `init_done`, `mem[5]`=`INIT_VAL` and `rvalid` was never asserted.
- **`clr` mid-operation.** Write 16'h0060 to 9, read 9, then pulse `clr` with a concurrent read of 9:
  - the first read's `rvalid`=1 with 16'h0060;
  - the concurrent read is dropped, `init_done`=0 for 256 edges;
  - after re-init, `mem[9]`=`INIT_VAL`.
- **Async reset mid-init.** Assert `rst` at init edge 100: `init_done`=0, `rvalid`=0 and `rdata`=0 immediately. After release, the full 256-edge init completes.
